mem_ctrl: RTL

- Memory controller inside riscv_top, between the core and the byte-wide RAM/IO bus.
- Arbitrates two clients: instruction fetch (IF, 4-byte reads) and load/store unit (LS, 1/2/4-byte reads and writes).
- Serializes each access into byte transfers on the synchronous RAM port.
- Holds IO writes while the host IO buffer is full.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the core-to-RAM byte-serial memory controller:
// FSM states, access size codes and the IO region test.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // Index of the final byte of an access; the illegal code 3 behaves as a word.
  function automatic logic [1:0] size_last(input logic [1:0] size);
    case (size)
      SIZE_B:  return 2'd0;
      SIZE_H:  return 2'd1;
      SIZE_W:  return 2'd3;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] region, input logic [1:0] io_region);
    return region == io_region;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF and LS clients onto a byte-wide synchronous RAM/IO bus,
// serialising every access into single-byte transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic [31:0]           ls_rdata,
  output logic                  ls_done
);

  state_e                state_q;
  logic [2:0]            cnt_q;
  logic [1:0]            last_q;
  logic                  is_ls_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [7:0]            mem_dout_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rd_buf_q;
  logic                  iss_valid_q;
  logic [1:0]            iss_idx_q;
  logic                  if_done_q;
  logic                  ls_done_q;
  logic [31:0]           if_data_q;
  logic [31:0]           ls_rdata_q;

  logic                  io_stall;
  logic                  at_last;
  logic [1:0]            cnt_inc;
  logic                  accept;
  logic                  accept_ls;
  logic [31:0]           rd_merge;

  assign io_stall  = is_io(mem_a_q[17:16], IO_BASE[17:16]) && io_buffer_full;
  assign at_last   = (cnt_q == {1'b0, last_q});
  assign cnt_inc   = cnt_q[1:0] + 2'd1;
  assign accept    = rdy_in && !clear_in && (state_q == ST_IDLE) &&
                     ((ls_req && !ls_done_q) || (if_req && !if_done_q));
  assign accept_ls = accept && ls_req && !ls_done_q;

  // The final byte arrives on mem_din in the done cycle itself.
  always_comb begin
    rd_merge = rd_buf_q;
    rd_merge[8*last_q +: 8] = mem_din;
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = (state_q == ST_WRITE) && rdy_in && !io_stall;
  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_data  = if_done_q ? rd_merge : if_data_q;
  assign ls_rdata = (ls_done_q && !we_q) ? rd_merge : ls_rdata_q;

  // The RAM keeps answering while rdy_in is low, so read bytes are tracked
  // against whatever address was on the bus in the previous cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      iss_valid_q <= 1'b0;
      iss_idx_q   <= 2'd0;
      rd_buf_q    <= '0;
    end else begin
      iss_valid_q <= (state_q == ST_READ);
      iss_idx_q   <= cnt_q[1:0];
      if (accept) begin
        rd_buf_q <= '0;
      end else if (iss_valid_q) begin
        rd_buf_q[8*iss_idx_q +: 8] <= mem_din;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      is_ls_q    <= 1'b0;
      we_q       <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      wdata_q    <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy_in) begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      if (if_done_q) if_data_q <= rd_merge;
      if (ls_done_q && !we_q) ls_rdata_q <= rd_merge;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            if (accept_ls) begin
              is_ls_q    <= 1'b1;
              we_q       <= ls_we;
              mem_a_q    <= ls_addr;
              last_q     <= size_last(ls_size);
              wdata_q    <= ls_wdata;
              mem_dout_q <= ls_wdata[7:0];
              state_q    <= ls_we ? ST_WRITE : ST_READ;
            end else begin
              is_ls_q <= 1'b0;
              we_q    <= 1'b0;
              mem_a_q <= if_addr;
              last_q  <= 2'd3;
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (clear_in) begin
            state_q <= ST_IDLE;
          end else if (at_last) begin
            state_q <= ST_IDLE;
            if (is_ls_q) ls_done_q <= 1'b1;
            else         if_done_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 3'd1;
            mem_a_q <= mem_a_q + 1'b1;
          end
        end
        ST_WRITE: begin
          if (!io_stall) begin
            if (at_last) begin
              state_q   <= ST_IDLE;
              ls_done_q <= 1'b1;
            end else begin
              cnt_q      <= cnt_q + 3'd1;
              mem_a_q    <= mem_a_q + 1'b1;
              mem_dout_q <= wdata_q[8*cnt_inc +: 8];
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
